alu_muldiv_ctrl: RTL and testbench
==================================

Name: alu_muldiv_ctrl

Overview:
Second-generation ALU control for the MIPS datapath.
- Keeps the combinational op/funct → 4-bit ALU control decode, with extended codes.
- Adds an iterative multiply/divide engine with HI/LO registers and a busy/stall handshake toward the pipeline control.
- Sits in EX beside the ALU. Accepts R-type mult/multu/div/divu, serves mfhi/mflo, and stalls the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, datapath width of operands, HI and LO (≥4, power of two)
OP_W, 4, width of ALUOp bus from main control

Ports:
clk  in  1  system clock
rst_n  in  1  reset
valid  in  1  EX-stage instruction valid
op  in  OP_W  ALUOp from main control
funct  in  6  instruction funct field
rs_val  in  WIDTH  operand A (multiplicand / dividend)
rt_val  in  WIDTH  operand B (multiplier / divisor)
control  out  4  ALU operation select (combinational)
busy  out  1  mul/div engine active
stall  out  1  hold the pipeline this cycle
hilo_rd  out  1  mfhi/mflo result valid on hilo_data
hilo_data  out  WIDTH  HI or LO value
done  out  1  one-cycle pulse when HI/LO are written
div_by_zero  out  1  pulse with done for a divide with rt_val==0

Behaviour:
- Reset is asynchronous and active-low on rst_n. Reset state: state=IDLE, counter=0, HI=LO=0, busy=0, done=0, div_by_zero=0. Reset mid-operation aborts the operation; HI/LO stay 0.
- control decode (combinational, independent of state):
  - op 0000→0010; op 0001→0110; op 0011→0000; op 0101→0001; op 0100→0100; op 0110→0111.
  - op 0010 decodes funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111 (nor)→1100, 101011 (sltu)→1111.
  - Everything else, including mul/div functs, →0000.
- Mul/div functs, valid only with op=0010: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010.
- Start rule:
  - valid & md-op & state==IDLE starts an operation at the clock edge; operands are latched, the signed/unsigned flag is latched, and the counter is loaded with WIDTH.
  - For signed ops, operand magnitudes are latched and result signs are recorded: product sign = a^b, quotient sign = a^b, remainder sign = a.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL or DIV on start.
  - MUL: one shift-add step per cycle.
  - DIV: one restoring shift-subtract step per cycle.
  - MUL/DIV: the counter decrements each cycle; counter hits 0 → FIX.
  - FIX: apply sign correction, write HI/LO on the exit edge, assert done (and div_by_zero if applicable) during FIX; FIX → IDLE.
- Latency: busy=1 for exactly WIDTH+1 cycles after the start edge (WIDTH iterations + FIX). New HI/LO are visible the cycle after FIX.
- Results:
  - mult/multu: {HI,LO} = 2·WIDTH-bit product.
  - div/divu: LO = quotient, HI = remainder (remainder takes the dividend's sign).
- Divide by zero: LO = all ones, HI = rs_val (raw), div_by_zero pulses. Signed and unsigned alike.
- Signed overflow (MIN / −1): LO = MIN, HI = 0, no flag.
- stall = busy & valid & (md-op | mfhi | mflo). A md-op presented while busy is not accepted; it is re-presented by the held pipeline. Non-md instructions never stall.
- mfhi/mflo:
  - When valid & !busy: hilo_rd=1, hilo_data=HI or LO, combinational from the registers.
  - When busy: hilo_rd=0, stall=1.
  - During FIX, mfhi/mflo still stall; the next cycle returns the new value.
- hilo_data=0 when hilo_rd=0.
- Arithmetic: accumulator is WIDTH+1 bits internally. All WIDTH results are truncated modulo 2^WIDTH except the full 2·WIDTH product.

Decomposition:
- Shared package/include holds:
  - ALUOp encodings (4-bit).
  - funct constants (add/sub/and/or/slt/nor/sltu/mult/multu/div/divu/mfhi/mflo).
  - ALU control codes.
  - FSM state encodings.
- One natural sub-module: muldiv_core (FSM, counter, shift-add/subtract datapath, sign fix, HI/LO). The decode and stall logic stay in the top.

Test Plan:
- Decode sweep: op=0010 with each listed funct, plus every op → control matches the table; unknown funct 111111 → 0000; stall=0.
- multu with WIDTH=32, rs=0xFFFFFFFF, rt=0xFFFFFFFF → busy for 33 cycles, done pulse, then mfhi=0xFFFFFFFE and mflo=0x00000001.
- mult with rs=−7, rt=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then div with rs=−7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with rs=100, rt=0 → LO=0xFFFFFFFF, HI=100, div_by_zero=1 in the done cycle. div with rs=0x80000000, rt=−1 → LO=0x80000000, HI=0, no flag.
- mflo issued 5 cycles after a mult start → stall=1, hilo_rd=0 until busy falls, then hilo_rd=1 with the new LO. A second mult during busy is not accepted (HI/LO reflect only the first).
- Assert rst_n=0 at iteration 10 of a div → busy=0 and HI=LO=0 immediately, no done pulse. The next divu 9/4 after release → LO=2, HI=1.

Source files
------------

// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared encodings for the ALU control decode and the iterative mul/div engine.
// Holds ALUOp values, funct codes, ALU control codes and the engine FSM states.
package alu_muldiv_ctrl_pkg;

    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
    localparam logic [3:0] ALUOP_AND   = 4'b0011;
    localparam logic [3:0] ALUOP_EXT4  = 4'b0100;
    localparam logic [3:0] ALUOP_OR    = 4'b0101;
    localparam logic [3:0] ALUOP_SLT   = 4'b0110;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_EXT4 = 4'b0100;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with a final
// sign-fix cycle that writes HI/LO.
module alu_muldiv_ctrl_muldiv_core
    import alu_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opnd, acc_hi, acc_lo, a_raw;
    logic               neg_lo, neg_hi, b_zero, mul_op;

    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // Remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
        prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = neg_lo ? -acc_lo : acc_lo;
        rem_fix   = neg_hi ? -acc_hi : acc_hi;
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_FIX);
    assign div_by_zero = (state == ST_FIX) && !mul_op && b_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            a_raw  <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            b_zero <= 1'b0;
            mul_op <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opnd   <= is_div ? b_mag : a_mag;
                        acc_hi <= '0;
                        acc_lo <= is_div ? a_mag : b_mag;
                        a_raw  <= a;
                        b_zero <= (b == '0);
                        mul_op <= !is_div;
                        neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi <= is_signed && a[WIDTH-1];
                        count  <= CW'(WIDTH);
                        state  <= is_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= ST_FIX;
                end
                ST_DIV: begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    count  <= count - CW'(1);
                    if (count == CW'(1)) state <= ST_FIX;
                end
                default: begin
                    if (mul_op) begin
                        {hi, lo} <= prod_fix;
                    end else if (b_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control: ALUOp/funct decode, mul/div issue, pipeline stall and
// mfhi/mflo read-out around the iterative mul/div engine.
module alu_muldiv_ctrl
    import alu_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [OP_W-1:0]  op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       control,
    output logic             busy,
    output logic             stall,
    output logic             hilo_rd,
    output logic [WIDTH-1:0] hilo_data,
    output logic             done,
    output logic             div_by_zero
);
    logic             is_rtype, md_op, is_mfhi, is_mflo, start;
    logic [WIDTH-1:0] hi, lo;

    always_comb begin
        control = CTL_AND;
        if (op == OP_W'(ALUOP_RTYPE)) begin
            case (funct)
                FUNCT_ADD:  control = CTL_ADD;
                FUNCT_SUB:  control = CTL_SUB;
                FUNCT_AND:  control = CTL_AND;
                FUNCT_OR:   control = CTL_OR;
                FUNCT_SLT:  control = CTL_SLT;
                FUNCT_NOR:  control = CTL_NOR;
                FUNCT_SLTU: control = CTL_SLTU;
                default:    control = CTL_AND;
            endcase
        end else begin
            case (op)
                OP_W'(ALUOP_ADD):  control = CTL_ADD;
                OP_W'(ALUOP_SUB):  control = CTL_SUB;
                OP_W'(ALUOP_AND):  control = CTL_AND;
                OP_W'(ALUOP_OR):   control = CTL_OR;
                OP_W'(ALUOP_EXT4): control = CTL_EXT4;
                OP_W'(ALUOP_SLT):  control = CTL_SLT;
                default:           control = CTL_AND;
            endcase
        end
    end

    assign is_rtype = (op == OP_W'(ALUOP_RTYPE));
    assign md_op    = is_rtype && is_md_funct(funct);
    assign is_mfhi  = is_rtype && (funct == FUNCT_MFHI);
    assign is_mflo  = is_rtype && (funct == FUNCT_MFLO);

    // A held md-op is re-presented by the stalled pipeline, so only issue when idle.
    assign start     = valid && md_op && !busy;
    assign stall     = busy && valid && (md_op || is_mfhi || is_mflo);
    assign hilo_rd   = valid && !busy && (is_mfhi || is_mflo);
    assign hilo_data = hilo_rd ? (is_mfhi ? hi : lo) : '0;

    alu_muldiv_ctrl_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_div      ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU)),
        .is_signed   ((funct == FUNCT_MULT) || (funct == FUNCT_DIV)),
        .a           (rs_val),
        .b           (rt_val),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: decode table, mul/div results against
// a plain-arithmetic reference model, latency, stall and reset behaviour.
module tb_alu_muldiv_ctrl;
    localparam int W = 32;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A;
    localparam logic [5:0] F_DIVU = 6'h1B, F_MFHI = 6'h10, F_MFLO = 6'h12;

    logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
    logic [3:0]    op = '0;
    logic [5:0]    funct = '0;
    logic [W-1:0]  rs_val = '0, rt_val = '0;
    logic [3:0]    control;
    logic          busy, stall, hilo_rd, done, div_by_zero;
    logic [W-1:0]  hilo_data;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_ctrl #(.WIDTH(W), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .control(control), .busy(busy),
        .stall(stall), .hilo_rd(hilo_rd), .hilo_data(hilo_data), .done(done),
        .div_by_zero(div_by_zero)
    );

    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output int dbz);
        longint sa, sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        dbz = 0;
        if (f == F_MULT) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0];
        end else if (f == F_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 0) begin
            hi = a; lo = '1; dbz = 1;
        end else if (f == F_DIV) begin
            p = sa / sb; lo = p[31:0];
            p = sa % sb; hi = p[31:0];
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    // Issue one md-op and follow it until busy drops (bounded).
    task automatic issue_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int cycles, output int done_cnt, output int done_at,
                            output int dbz_cnt);
        @(posedge clk); #1;
        valid = 1'b1; op = 4'b0010; funct = f; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        valid = 1'b0; op = 4'b0000; funct = 6'h00; #1;
        cycles = 0; done_cnt = 0; done_at = -1; dbz_cnt = 0;
        while (busy && cycles < 200) begin
            if (done) begin done_cnt++; done_at = cycles; end
            if (div_by_zero) dbz_cnt++;
            cycles++;
            @(posedge clk); #2;
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo, output bit rd_ok);
        @(posedge clk); #1;
        valid = 1'b1; op = 4'b0010; funct = F_MFHI; #1;
        hi = hilo_data; rd_ok = hilo_rd && !stall;
        funct = F_MFLO; #1;
        lo = hilo_data; rd_ok = rd_ok && hilo_rd && !stall;
        valid = 1'b0; op = 4'b0000; funct = 6'h00;
    endtask

    task automatic test_reset();
        logic [W-1:0] hi, lo; bit ok;
        #1;
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero}); end
        #10 rst_n = 1'b1;
        read_hilo(hi, lo, ok);
        checks++; if (!ok || hi !== '0 || lo !== '0) begin
            errors++; $display("FAIL reset_hilo: got rd=%0b hi=%h lo=%h want rd=1 hi=0 lo=0", ok, hi, lo); end
    endtask

    task automatic test_decode();
        logic [3:0] exp_op [16] = '{4'h2, 4'h6, 4'h0, 4'h0, 4'h4, 4'h1, 4'h7, 4'h0,
                                    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [5:0] fl [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h2B,
                                6'h3F, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO};
        logic [3:0] fe [14] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC, 4'hF,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        @(posedge clk); #1;
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) continue;
            op = 4'(i); funct = 6'($urandom); #1;
            checks++; if (control !== exp_op[i] || stall !== 1'b0) begin
                errors++; $display("FAIL decode_op%0d: got ctl=%h stall=%b want ctl=%h stall=0",
                                   i, control, stall, exp_op[i]); end
        end
        op = 4'b0010;
        for (int i = 0; i < 14; i++) begin
            funct = fl[i]; #1;
            checks++; if (control !== fe[i] || stall !== 1'b0) begin
                errors++; $display("FAIL decode_funct%h: got ctl=%h stall=%b want ctl=%h stall=0",
                                   fl[i], control, stall, fe[i]); end
        end
        valid = 1'b0; op = 4'b0000; funct = 6'h00;
    endtask

    task automatic run_and_check(input string name, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] want_hi, input logic [W-1:0] want_lo,
                                 input int want_dbz);
        int cyc, dcnt, dat, zcnt; logic [W-1:0] hi, lo; bit ok;
        issue_md(f, a, b, cyc, dcnt, dat, zcnt);
        checks++; if (cyc != W + 1 || dcnt != 1 || dat != W) begin
            errors++; $display("FAIL %s_timing: got busy=%0d done=%0d@%0d want busy=%0d done=1@%0d",
                               name, cyc, dcnt, dat, W + 1, W); end
        checks++; if (zcnt != want_dbz) begin
            errors++; $display("FAIL %s_dbz: got %0d want %0d", name, zcnt, want_dbz); end
        read_hilo(hi, lo, ok);
        checks++; if (!ok || hi !== want_hi || lo !== want_lo) begin
            errors++; $display("FAIL %s_hilo: got rd=%0b hi=%h lo=%h want rd=1 hi=%h lo=%h",
                               name, ok, hi, lo, want_hi, want_lo); end
    endtask

    task automatic test_directed();
        run_and_check("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_and_check("mult_neg", F_MULT, -32'sd7, 32'sd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_and_check("div_neg", F_DIV, -32'sd7, 32'sd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_and_check("divu_zero", F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1);
        run_and_check("div_zero", F_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1);
        run_and_check("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b, ehi, elo, hi, lo; int dz, n; bit ok;
        a = $urandom; b = $urandom;
        model(F_MULT, a, b, ehi, elo, dz);
        @(posedge clk); #1;
        valid = 1'b1; op = 4'b0010; funct = F_MULT; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        for (int c = 1; c < 5; c++) begin
            funct = F_MULT; rs_val = $urandom; rt_val = $urandom; #1;
            checks++; if (stall !== 1'b1 || hilo_rd !== 1'b0) begin
                errors++; $display("FAIL stall_md c%0d: got stall=%b rd=%b want stall=1 rd=0",
                                   c, stall, hilo_rd); end
            @(posedge clk); #1;
        end
        funct = F_MFLO; #1;
        n = 0;
        while (busy && n < 100) begin
            checks++; if (stall !== 1'b1 || hilo_rd !== 1'b0 || hilo_data !== '0) begin
                errors++; $display("FAIL stall_mflo n%0d: got stall=%b rd=%b data=%h want 1 0 0",
                                   n, stall, hilo_rd, hilo_data); end
            n++;
            @(posedge clk); #2;
        end
        checks++; if (n + 4 != W + 1 || stall !== 1'b0 || hilo_rd !== 1'b1 || hilo_data !== elo) begin
            errors++; $display("FAIL stall_release: got busy=%0d stall=%b rd=%b lo=%h want busy=%0d 0 1 lo=%h",
                               n + 4, stall, hilo_rd, hilo_data, W + 1, elo); end
        valid = 1'b0; funct = 6'h00; op = 4'b0000;
        read_hilo(hi, lo, ok);
        checks++; if (!ok || hi !== ehi || lo !== elo) begin
            errors++; $display("FAIL stall_first_only: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, ehi, elo); end
    endtask

    task automatic test_reset_mid();
        int dcnt;
        @(posedge clk); #1;
        valid = 1'b1; op = 4'b0010; funct = F_DIV; rs_val = $urandom; rt_val = $urandom | 32'h1;
        @(posedge clk); #1;
        valid = 1'b0; funct = 6'h00; op = 4'b0000;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        #2 rst_n = 1'b0; #1;
        valid = 1'b1; op = 4'b0010; funct = F_MFHI; #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dcnt != 0 || hilo_data !== '0) begin
            errors++; $display("FAIL rst_mid_hi: got busy=%b done=%b pulses=%0d hi=%h want 0 0 0 0",
                               busy, done, dcnt, hilo_data); end
        funct = F_MFLO; #1;
        checks++; if (hilo_data !== '0 || hilo_rd !== 1'b1) begin
            errors++; $display("FAIL rst_mid_lo: got rd=%b lo=%h want rd=1 lo=0", hilo_rd, hilo_data); end
        valid = 1'b0; funct = 6'h00; op = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        checks++; if (dcnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet: got pulses=%0d busy=%b want 0 0", dcnt, busy); end
        rst_n = 1'b1;
        run_and_check("after_rst", F_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 0);
    endtask

    task automatic test_random();
        logic [5:0] fs [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [W-1:0] a, b, ehi, elo; int dz; logic [5:0] f;
        for (int i = 0; i < 24; i++) begin
            f = fs[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: a = W'($urandom_range(0, 1000));
                default: ;
            endcase
            model(f, a, b, ehi, elo, dz);
            run_and_check($sformatf("rand%0d_f%h", i, f), f, a, b, ehi, elo, dz);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_directed();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
